msrv32_iadder_arbiter: RTL and testbench
========================================

// Module: msrv32_iadder_arbiter
// PURPOSE
//  Shares the single 32-bit immediate adder (base + imm, base = rs1 or pc) between two requesters:
//  req0 = branch/jump target unit, req1 = load/store address generator.
//  Round-robin arbitration, valid/ready handshakes on both request ports, drives the adder's operand
//  inputs, registers the adder sum, returns it with the requester id on a valid/ready response port.
// PARAMETERS
//  WIDTH        32    operand/result width
//  RESET_LAST   1     requester treated as "last granted" after reset (1 -> req0 wins first tie)
// PORTS
//  ms_riscv32_mp_clk_in   in   1      clock, all state on rising edge
//  ms_riscv32_mp_rst_in   in   1      synchronous reset, active-high
//  reqN_valid_in          in   1      request N valid (N = 0,1)
//  reqN_ready_out         out  1      request N accepted this cycle (valid & ready = transfer)
//  reqN_pc_in             in   WIDTH  request N pc operand
//  reqN_rs_1_in           in   WIDTH  request N rs1 operand
//  reqN_imm_in            in   WIDTH  request N immediate
//  reqN_src_in            in   1      request N base select: 1 = rs1, 0 = pc
//  pc_out                 out  WIDTH  to adder pc_in
//  rs_1_out               out  WIDTH  to adder rs_1_in
//  imm_out                out  WIDTH  to adder imm_in
//  iadder_src_out         out  1      to adder iadder_src_in
//  iadder_in              in   WIDTH  from adder iadder_out (combinational sum)
//  rsp_valid_out          out  1      response valid
//  rsp_ready_in           in   1      response consumer ready
//  rsp_id_out             out  1      requester id of response
//  rsp_data_out           out  WIDTH  registered sum
// BEHAVIOUR
//  FSM: IDLE, RESP. Reset -> IDLE; rsp_valid_out=0, rsp_id_out=0, rsp_data_out=0, last_grant=RESET_LAST.
//  can_accept = (state==IDLE) | (state==RESP & rsp_ready_in).
//  Grant (combinational): if can_accept & only reqN valid -> N; both valid -> requester != last_grant;
//   none valid or !can_accept -> no grant. reqN_ready_out = can_accept & grant==N (never both high).
//  Adder operands = granted request's pc/rs1/imm/src; with no grant, operands held at req0's inputs.
//  On grant edge: rsp_data_out <= iadder_in, rsp_id_out <= N, last_grant <= N, state -> RESP.
//  RESP: rsp_valid_out=1; data/id stable while rsp_ready_in=0.
//   rsp_ready_in=1 & new grant -> stay RESP with new data (back-to-back, 1 result/cycle).
//   rsp_ready_in=1 & no grant -> IDLE, rsp_valid_out=0 next cycle.
//  Latency: request accepted in cycle T -> rsp_valid_out high in T+1.
//  Sum is modulo 2^WIDTH; carry out discarded (0xFFFFFFFC + 8 = 0x00000004).
//  Request inputs must stay stable while valid & !ready; a withdrawn request is simply not granted.
//  Single request with no contention is granted regardless of last_grant (no bubble).
//  Reset mid-RESP: pending response dropped, no ready asserted in the reset cycle.
// CONFIGURATION
//  MSRV32_IADDER_ALIGN_EN defined: for grants with src=1 (rs1 base, JALR), rsp_data_out bit 0 is
//   forced to 0 when captured; src=0 results are unchanged.
//  Not defined: rsp_data_out = raw iadder_in for all requests.
// TESTING
//  Reset, no requests -> readys 0, rsp_valid_out 0, rsp_data_out 0 for 5 cycles.
//  req0 only: pc=0x100, imm=0x20, src=0 -> req0_ready_out 1 in T, rsp 0x120 id 0 in T+1.
//  Both valid continuously, rsp_ready_in=1 -> grants alternate 0,1,0,1, one response per cycle.
//  rsp_ready_in=0 for 3 cycles in RESP -> both readys 0, data/id held; release -> next grant same cycle.
//  req1 src=1 rs1=0x1001, imm=0x4 -> 0x1005 without macro, 0x1004 with MSRV32_IADDER_ALIGN_EN.
//  Wrap: pc=0xFFFFFFFC, imm=0x8 -> 0x00000004; reset asserted in RESP -> rsp_valid_out 0 next cycle.

Source files
------------

// File: rtl/msrv32_iadder_arbiter.sv
// ============================================================================
// msrv32_iadder_arbiter : round-robin share of the immediate adder between
// the branch target unit (req0) and the load/store AGU (req1).
// Optional feature macro: MSRV32_IADDER_ALIGN_EN (clear bit 0 of rs1-based sums)
// Revision: 1.0
// ============================================================================
`default_nettype none

module msrv32_iadder_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RESET_LAST = 1
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic [WIDTH-1:0] req0_pc_in,
  input  logic [WIDTH-1:0] req0_rs_1_in,
  input  logic [WIDTH-1:0] req0_imm_in,
  input  logic             req0_src_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic [WIDTH-1:0] req1_pc_in,
  input  logic [WIDTH-1:0] req1_rs_1_in,
  input  logic [WIDTH-1:0] req1_imm_in,
  input  logic             req1_src_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] rs_1_out,
  output logic [WIDTH-1:0] imm_out,
  output logic             iadder_src_out,
  input  logic [WIDTH-1:0] iadder_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic             rsp_id_out,
  output logic [WIDTH-1:0] rsp_data_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             can_accept;
  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] sum_capt;

  // Reset gates acceptance so no handshake completes in a reset cycle.
  assign can_accept = !ms_riscv32_mp_rst_in &&
                      ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_in));

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (can_accept) begin
      if (req0_valid_in && req1_valid_in) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid_in) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req1_valid_in) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign req0_ready_out = grant_valid && (grant_id == 1'b0);
  assign req1_ready_out = grant_valid && (grant_id == 1'b1);

  // Without a grant the adder simply sees req0's operands.
  always_comb begin
    if (grant_valid && grant_id) begin
      pc_out         = req1_pc_in;
      rs_1_out       = req1_rs_1_in;
      imm_out        = req1_imm_in;
      iadder_src_out = req1_src_in;
    end else begin
      pc_out         = req0_pc_in;
      rs_1_out       = req0_rs_1_in;
      imm_out        = req0_imm_in;
      iadder_src_out = req0_src_in;
    end
  end

  always_comb begin
    sum_capt = iadder_in;
`ifdef MSRV32_IADDER_ALIGN_EN
    if (iadder_src_out) begin
      sum_capt[0] = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    if (grant_valid) begin
      state_d      = RESP;
      last_grant_d = grant_id;
      rsp_id_d     = grant_id;
      rsp_data_d   = sum_capt;
    end else if ((state_q == RESP) && rsp_ready_in) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= IDLE;
      last_grant_q <= 1'(RESET_LAST);
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid_out = (state_q == RESP);
  assign rsp_id_out    = rsp_id_q;
  assign rsp_data_out  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_msrv32_iadder_arbiter.sv
// ============================================================================
// tb_msrv32_iadder_arbiter : directed scoreboard bench for the adder arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_msrv32_iadder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_pc, req0_rs1, req0_imm;
  logic [31:0] req1_pc, req1_rs1, req1_imm;
  logic        req0_src, req1_src;
  logic [31:0] pc_o, rs1_o, imm_o, sum;
  logic        src_o;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int errors = 0;
  int checks = 0;
  logic [32:0] sb[$];
  logic [31:0] exp0, exp1;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared immediate adder.
  assign sum = (src_o ? rs1_o : pc_o) + imm_o;

  msrv32_iadder_arbiter #(.WIDTH(32), .RESET_LAST(1)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .req0_valid_in(req0_valid),
    .req0_ready_out(req0_ready),
    .req0_pc_in(req0_pc),
    .req0_rs_1_in(req0_rs1),
    .req0_imm_in(req0_imm),
    .req0_src_in(req0_src),
    .req1_valid_in(req1_valid),
    .req1_ready_out(req1_ready),
    .req1_pc_in(req1_pc),
    .req1_rs_1_in(req1_rs1),
    .req1_imm_in(req1_imm),
    .req1_src_in(req1_src),
    .pc_out(pc_o),
    .rs_1_out(rs1_o),
    .imm_out(imm_o),
    .iadder_src_out(src_o),
    .iadder_in(sum),
    .rsp_valid_out(rsp_valid),
    .rsp_ready_in(rsp_ready),
    .rsp_id_out(rsp_id),
    .rsp_data_out(rsp_data)
  );

  function automatic logic [31:0] exp_sum(input logic [31:0] pc, input logic [31:0] rs1,
                                          input logic [31:0] imm, input logic src);
    logic [31:0] r;
    r = (src ? rs1 : pc) + imm;
`ifdef MSRV32_IADDER_ALIGN_EN
    if (src) r[0] = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req0(input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] imm, input logic src);
    req0_pc = pc; req0_rs1 = rs1; req0_imm = imm; req0_src = src;
    exp0 = exp_sum(pc, rs1, imm, src);
  endtask

  task automatic set_req1(input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] imm, input logic src);
    req1_pc = pc; req1_rs1 = rs1; req1_imm = imm; req1_src = src;
    exp1 = exp_sum(pc, rs1, imm, src);
  endtask

  // One clock cycle: drive, check readys, clock, then check the response port.
  task automatic step(input string tag, input logic v0, input logic v1, input logic rr,
                      input logic e0, input logic e1);
    logic pop;
    req0_valid = v0; req1_valid = v1; rsp_ready = rr;
    #1;
    check({tag, ".r0"}, {31'd0, req0_ready}, {31'd0, e0});
    check({tag, ".r1"}, {31'd0, req1_ready}, {31'd0, e1});
    pop = (sb.size() != 0) && rr;
    if (e0) sb.push_back({1'b0, exp0});
    if (e1) sb.push_back({1'b1, exp1});
    @(posedge clk); #1;
    if (pop) void'(sb.pop_front());
    check({tag, ".vld"}, {31'd0, rsp_valid}, {31'd0, (sb.size() != 0)});
    if (sb.size() != 0) begin
      check({tag, ".data"}, rsp_data, sb[0][31:0]);
      check({tag, ".id"}, {31'd0, rsp_id}, {31'd0, sb[0][32]});
    end
  endtask

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    set_req0(32'h0, 32'h0, 32'h0, 1'b0);
    set_req1(32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      step("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("idle.data", rsp_data, 32'h0);
    end

    // Single req0, pc + imm
    set_req0(32'h100, 32'hDEAD, 32'h20, 1'b0);
    check("req0.exp", exp0, 32'h120);
    step("req0", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("drain0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Contention: last grant was 0, so alternation starts with 1
    set_req0(32'h2000, 32'h0, 32'h10, 1'b0);
    set_req1(32'h0, 32'h3000, 32'h44, 1'b1);
    step("rr1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    set_req1(32'h0, 32'h3100, 32'h40, 1'b1);
    step("rr2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    set_req0(32'h2200, 32'h0, 32'h8, 1'b0);
    step("rr3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step("rr4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("drain1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Backpressure holds the response and blocks both requesters
    set_req1(32'h0, 32'h5555, 32'h11, 1'b1);
    step("bp.g", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("bp.hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bp.rel", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("drain2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // rs1 base with odd result (alignment option)
    set_req1(32'h0, 32'h1001, 32'h4, 1'b1);
`ifdef MSRV32_IADDER_ALIGN_EN
    check("align.exp", exp1, 32'h1004);
`else
    check("align.exp", exp1, 32'h1005);
`endif
    step("src1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    step("drain3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Lone req1 again right after req1 won: no bubble
    set_req1(32'h700, 32'h0, 32'h7, 1'b0);
    step("solo1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Wraparound, back-to-back with the previous response
    set_req0(32'hFFFF_FFFC, 32'h0, 32'h8, 1'b0);
    check("wrap.exp", exp0, 32'h4);
    step("wrap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset while a response is pending
    rst = 1'b1; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    check("rst.r0", {31'd0, req0_ready}, 32'd0);
    check("rst.r1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    sb.delete();
    check("rst.vld", {31'd0, rsp_valid}, 32'd0);
    check("rst.data", rsp_data, 32'h0);
    rst = 1'b0;
    step("post", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
